// File: rtl/cache_line_fill.sv
// -----------------------------------------------------------------------------
// cache_line_fill
//
// Write side of a single-line cache. On a miss the requester pulses fillReq
// with the wanted tag; the block then holds memReq high and accepts one byte
// per valid memory beat, in ascending offset order, into a 32-byte line store.
// When the last byte lands it spends one cycle in DONE, which commits
// lineTag/lineValid and raises the one-cycle fillDone pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   fillReq    start a fill of fillTag (sampled only when idle)
//   fillTag    tag of the line to fetch
//   fillBusy   high while filling and in the commit cycle
//   memReq     level request to memory, held for the whole burst
//   memTag     latched tag being fetched
//   memValid   memData carries a valid beat this cycle
//   memData    fill beat
//   fillDone   one-cycle pulse: line committed
//   lineValid  line holds valid data for lineTag
//   lineTag    tag of the resident line
//   rdOffset   read byte select
//   rdData     line[rdOffset], combinational
//
// Optional feature (macro CACHE_STORE_EN): a store port
//   wrEn/wrTag/wrOffset/wrData in, wrHit out (combinational). A store
//   writes one byte of the resident line when it is valid, the tag matches
//   and no fill is in progress.
//
// LINE_BYTES must equal 2**OFF_W: the fill counter relies on wrapping
// naturally back to zero after the last byte.
// -----------------------------------------------------------------------------
module cache_line_fill #(
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 8,
  parameter int LINE_BYTES = 32,
  parameter int OFF_W      = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fillReq,
  input  logic [TAG_W-1:0]  fillTag,
  output logic              fillBusy,
  output logic              memReq,
  output logic [TAG_W-1:0]  memTag,
  input  logic              memValid,
  input  logic [DATA_W-1:0] memData,
  output logic              fillDone,
  output logic              lineValid,
  output logic [TAG_W-1:0]  lineTag,
  input  logic [OFF_W-1:0]  rdOffset,
  output logic [DATA_W-1:0] rdData
`ifdef CACHE_STORE_EN
  ,
  input  logic              wrEn,
  input  logic [TAG_W-1:0]  wrTag,
  input  logic [OFF_W-1:0]  wrOffset,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrHit
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(LINE_BYTES - 1);

  state_t             state_reg, state_next;
  logic [OFF_W-1:0]   count_reg, count_next;
  logic               mem_req_reg, mem_req_next;
  logic [TAG_W-1:0]   mem_tag_reg, mem_tag_next;
  logic               fill_done_reg, fill_done_next;
  logic               line_valid_reg, line_valid_next;
  logic [TAG_W-1:0]   line_tag_reg, line_tag_next;
  logic               fill_we;

  // Line storage: intentionally not reset; lineValid qualifies its contents.
  logic [DATA_W-1:0]  line_mem [LINE_BYTES];
  logic               mem_we;
  logic [OFF_W-1:0]   mem_addr;
  logic [DATA_W-1:0]  mem_wdata;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      mem_req_reg    <= 1'b0;
      mem_tag_reg    <= '0;
      fill_done_reg  <= 1'b0;
      line_valid_reg <= 1'b0;
      line_tag_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      mem_req_reg    <= mem_req_next;
      mem_tag_reg    <= mem_tag_next;
      fill_done_reg  <= fill_done_next;
      line_valid_reg <= line_valid_next;
      line_tag_reg   <= line_tag_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    mem_req_next    = mem_req_reg;
    mem_tag_next    = mem_tag_reg;
    fill_done_next  = 1'b0;
    line_valid_next = line_valid_reg;
    line_tag_next   = line_tag_reg;
    fill_we         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fillReq) begin
          state_next      = FILL;
          mem_tag_next    = fillTag;
          line_valid_next = 1'b0;   // old line is being destroyed
          count_next      = '0;
          mem_req_next    = 1'b1;
        end
      end

      FILL: begin
        // Cycles without memValid are stalls: nothing moves.
        if (memValid) begin
          fill_we    = 1'b1;
          count_next = count_reg + 1'b1;  // wraps to 0 after the last byte
          if (count_reg == LAST_OFF) begin
            state_next   = DONE;
            mem_req_next = 1'b0;
          end
        end
      end

      DONE: begin
        // fillDone is registered, so it becomes visible together with
        // lineValid/lineTag on the cycle after DONE.
        fill_done_next  = 1'b1;
        line_valid_next = 1'b1;
        line_tag_next   = mem_tag_reg;
        state_next      = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store port and storage write mux. Fill writes only occur in FILL and
  // store hits only in IDLE, so the two sources never collide.
  // ---------------------------------------------------------------------------
`ifdef CACHE_STORE_EN
  assign wrHit = wrEn & line_valid_reg & (wrTag == line_tag_reg) & (state_reg == IDLE);
`endif

  always_comb begin
    mem_we    = fill_we;
    mem_addr  = count_reg;
    mem_wdata = memData;
`ifdef CACHE_STORE_EN
    if (wrHit) begin
      mem_we    = 1'b1;
      mem_addr  = wrOffset;
      mem_wdata = wrData;
    end
`endif
  end

  // A beat (or store) arriving in the same cycle as reset is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      line_mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fillBusy  = (state_reg != IDLE);
  assign memReq    = mem_req_reg;
  assign memTag    = mem_tag_reg;
  assign fillDone  = fill_done_reg;
  assign lineValid = line_valid_reg;
  assign lineTag   = line_tag_reg;
  assign rdData    = line_mem[rdOffset];

endmodule

// File: tb/tb_cache_line_fill.sv
// -----------------------------------------------------------------------------
// tb_cache_line_fill
//
// Directed sequence of fills with random beat data and random/regular stalls.
// The reference model is simply the expected contents of the 32-byte line
// (updated whenever the bench hands over an accepted beat) plus the expected
// tag/valid state; every cycle of a fill checks the handshake outputs.
// Store-port steps are compiled in when CACHE_STORE_EN is defined.
// -----------------------------------------------------------------------------
module tb_cache_line_fill;

  logic       clk;
  logic       reset;
  logic       fillReq;
  logic [3:0] fillTag;
  logic       fillBusy;
  logic       memReq;
  logic [3:0] memTag;
  logic       memValid;
  logic [7:0] memData;
  logic       fillDone;
  logic       lineValid;
  logic [3:0] lineTag;
  logic [4:0] rdOffset;
  logic [7:0] rdData;
`ifdef CACHE_STORE_EN
  logic       wrEn;
  logic [3:0] wrTag;
  logic [4:0] wrOffset;
  logic [7:0] wrData;
  logic       wrHit;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: expected line bytes.
  logic [7:0] ref_line [32];

  cache_line_fill dut (
    .clk       (clk),
    .reset     (reset),
    .fillReq   (fillReq),
    .fillTag   (fillTag),
    .fillBusy  (fillBusy),
    .memReq    (memReq),
    .memTag    (memTag),
    .memValid  (memValid),
    .memData   (memData),
    .fillDone  (fillDone),
    .lineValid (lineValid),
    .lineTag   (lineTag),
    .rdOffset  (rdOffset),
    .rdData    (rdData)
`ifdef CACHE_STORE_EN
    ,
    .wrEn      (wrEn),
    .wrTag     (wrTag),
    .wrOffset  (wrOffset),
    .wrData    (wrData),
    .wrHit     (wrHit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 32; i++) begin
      rdOffset = 5'(i);
      #1;
      check($sformatf("%s_rd%0d", tag, i), 32'(rdData), 32'(ref_line[i]));
    end
  endtask

  task automatic start_fill(input logic [3:0] tag);
    fillReq = 1'b1;
    fillTag = tag;
    tick();
    fillReq = 1'b0;
    check("start_memReq", 32'(memReq), 32'd1);
    check("start_memTag", 32'(memTag), 32'(tag));
    check("start_lineValid", 32'(lineValid), 32'd0);
    check("start_fillBusy", 32'(fillBusy), 32'd1);
  endtask

  // mode 0: no stalls, 1: stall every other cycle, 2: random stalls.
  task automatic feed_beats(input logic [3:0] tag, input int mode, input bit offx3,
                            input bit poke, input int nbeats);
    int beats = 0;
    int cyc = 0;
    bit v;
    while (beats < nbeats) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      memValid = v;
      memData  = offx3 ? 8'(beats * 3) : 8'($urandom);
      if (poke && beats == 5) begin
        fillReq = 1'b1;
        fillTag = 4'h3;
      end else begin
        fillReq = 1'b0;
      end
      check("fill_memReq", 32'(memReq), 32'd1);
      check("fill_memTag", 32'(memTag), 32'(tag));
      check("fill_lineValid", 32'(lineValid), 32'd0);
      check("fill_fillBusy", 32'(fillBusy), 32'd1);
      check("fill_fillDone", 32'(fillDone), 32'd0);
      if (v) begin
        ref_line[beats] = memData;
        beats++;
      end
      tick();
      cyc++;
    end
    memValid = 1'b0;
    fillReq  = 1'b0;
  endtask

  // Called right after the edge that took the 32nd beat.
  task automatic finish_fill(input logic [3:0] tag);
    check("done_memReq", 32'(memReq), 32'd0);
    check("done_fillBusy", 32'(fillBusy), 32'd1);
    check("done_fillDone", 32'(fillDone), 32'd0);
    check("done_lineValid", 32'(lineValid), 32'd0);
    tick();
    check("commit_fillDone", 32'(fillDone), 32'd1);
    check("commit_lineValid", 32'(lineValid), 32'd1);
    check("commit_lineTag", 32'(lineTag), 32'(tag));
    check("commit_fillBusy", 32'(fillBusy), 32'd0);
    check("commit_memReq", 32'(memReq), 32'd0);
    tick();
    check("post_fillDone", 32'(fillDone), 32'd0);
    check("post_lineValid", 32'(lineValid), 32'd1);
  endtask

  initial begin
    reset    = 1'b1;
    fillReq  = 1'b0;
    fillTag  = 4'h0;
    memValid = 1'b0;
    memData  = 8'h00;
    rdOffset = 5'd0;
`ifdef CACHE_STORE_EN
    wrEn     = 1'b0;
    wrTag    = 4'h0;
    wrOffset = 5'd0;
    wrData   = 8'h00;
`endif
    for (int i = 0; i < 32; i++) ref_line[i] = 8'h00;

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    check("rst_memReq", 32'(memReq), 32'd0);
    check("rst_memTag", 32'(memTag), 32'd0);
    check("rst_fillDone", 32'(fillDone), 32'd0);
    check("rst_lineValid", 32'(lineValid), 32'd0);
    check("rst_lineTag", 32'(lineTag), 32'd0);
    check("rst_fillBusy", 32'(fillBusy), 32'd0);

    // 1: back-to-back fill of tag A with data offset*3
    start_fill(4'hA);
    feed_beats(4'hA, 0, 1'b1, 1'b0, 32);
    finish_fill(4'hA);
    readback("t1");
    check("t1_rd31", 32'(ref_line[31]), 32'h5D);

    // 2: memValid low every other cycle
    start_fill(4'hA);
    feed_beats(4'hA, 1, 1'b0, 1'b0, 32);
    finish_fill(4'hA);
    readback("t2");

    // 3: fillReq with tag 3 during FILL is ignored
    start_fill(4'hA);
    feed_beats(4'hA, 2, 1'b0, 1'b1, 32);
    finish_fill(4'hA);
    readback("t3");

    // 4: reset after beat 10; same-cycle beat and fillReq are dropped
    start_fill(4'hA);
    feed_beats(4'hA, 2, 1'b0, 1'b0, 10);
    memValid = 1'b1;
    memData  = ~ref_line[10];
    fillReq  = 1'b1;
    fillTag  = 4'h3;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    memValid = 1'b0;
    fillReq  = 1'b0;
    check("t4_memReq", 32'(memReq), 32'd0);
    check("t4_lineValid", 32'(lineValid), 32'd0);
    check("t4_fillBusy", 32'(fillBusy), 32'd0);
    check("t4_memTag", 32'(memTag), 32'd0);
    check("t4_lineTag", 32'(lineTag), 32'd0);
    readback("t4");
    tick();
    check("t4_idle_fillBusy", 32'(fillBusy), 32'd0);
    start_fill(4'hA);
    feed_beats(4'hA, 2, 1'b0, 1'b0, 32);
    finish_fill(4'hA);
    readback("t4b");

    // 5: second fill (tag 5) over valid line A
    start_fill(4'h5);
    feed_beats(4'h5, 2, 1'b0, 1'b0, 32);
    finish_fill(4'h5);
    readback("t5");

`ifdef CACHE_STORE_EN
    // 6: stores
    start_fill(4'hA);
    feed_beats(4'hA, 0, 1'b0, 1'b0, 32);
    finish_fill(4'hA);
    wrEn     = 1'b1;
    wrTag    = 4'hA;
    wrOffset = 5'd7;
    wrData   = 8'hEE;
    #1;
    check("t6_hit", 32'(wrHit), 32'd1);
    tick();
    ref_line[7] = 8'hEE;
    wrTag  = 4'hB;
    wrData = 8'h44;
    #1;
    check("t6_miss_hit", 32'(wrHit), 32'd0);
    tick();
    wrEn = 1'b0;
    readback("t6a");

    // store and fillReq together: store lands, then the fill starts
    wrEn     = 1'b1;
    wrTag    = 4'hA;
    wrOffset = 5'd20;
    wrData   = 8'h5A;
    #1;
    check("t6_combo_hit", 32'(wrHit), 32'd1);
    start_fill(4'hA);
    ref_line[20] = 8'h5A;
    wrData = 8'h11;
    #1;
    check("t6_fill_hit", 32'(wrHit), 32'd0);
    tick();
    wrEn = 1'b0;
    rdOffset = 5'd20;
    #1;
    check("t6_combo_rd20", 32'(rdData), 32'h5A);
    feed_beats(4'hA, 2, 1'b0, 1'b0, 32);
    finish_fill(4'hA);
    readback("t6b");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
